// File: rtl/coin_pkg.sv
// Shared encodings for the coin acceptor: coin types, cent values, FSM states.
package coin_pkg;

    typedef enum logic [2:0] {
        CoinP = 3'd0,
        CoinN = 3'd1,
        CoinD = 3'd2,
        CoinQ = 3'd3,
        CoinB = 3'd4
    } coin_e;

    localparam int unsigned ValP = 1;
    localparam int unsigned ValN = 5;
    localparam int unsigned ValD = 10;
    localparam int unsigned ValQ = 25;
    localparam int unsigned ValB = 100;

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StChgReq  = 2'd1,
        StChgAck  = 2'd2,
        StChgWait = 2'd3
    } state_e;

    function automatic logic coin_type_valid(logic [2:0] t);
        return t <= CoinB;
    endfunction

    function automatic logic [6:0] coin_value(logic [2:0] t);
        case (t)
            CoinP:   return 7'(ValP);
            CoinN:   return 7'(ValN);
            CoinD:   return 7'(ValD);
            CoinQ:   return 7'(ValQ);
            CoinB:   return 7'(ValB);
            default: return 7'd0;
        endcase
    endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin/user and change-dispenser signals of the coin acceptor, grouped with modports.
interface coin_acceptor_if #(
    parameter int unsigned CREDIT_W = 9
);
    logic                coin_valid;
    logic [2:0]          coin_type;
    logic                item_req;
    logic                cancel;
    logic                coin_reject;
    logic                vend;
    logic                insufficient;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic                change_start;
    logic                avail_B;
    logic                avail_Q;
    logic                avail_D;
    logic                avail_N;
    logic                avail_P;
    logic                disp_B;
    logic                disp_Q;
    logic                disp_D;
    logic                disp_N;
    logic                disp_P;
    logic                change_done;
    logic                change_fault;

    modport master (
        output coin_valid, coin_type, item_req, cancel,
        output disp_B, disp_Q, disp_D, disp_N, disp_P, change_done,
        input  coin_reject, vend, insufficient, busy, credit, change_start,
        input  avail_B, avail_Q, avail_D, avail_N, avail_P, change_fault
    );

    modport slave (
        input  coin_valid, coin_type, item_req, cancel,
        input  disp_B, disp_Q, disp_D, disp_N, disp_P, change_done,
        output coin_reject, vend, insufficient, busy, credit, change_start,
        output avail_B, avail_Q, avail_D, avail_N, avail_P, change_fault
    );

endinterface

// File: rtl/coin_change_sel.sv
// Change selection: which denominations fit the remaining change, and the
// remaining value after the dispenser reports the coin it issued.
module coin_change_sel import coin_pkg::*; #(
    parameter int unsigned CREDIT_W = 9
) (
    input  logic [CREDIT_W-1:0] remaining_i,
    input  logic [4:0]          disp_i,       // {B, Q, D, N, P}
    output logic [4:0]          avail_o,      // {B, Q, D, N, P}
    output logic [CREDIT_W-1:0] remaining_o,
    output logic                fault_o
);

    localparam logic [CREDIT_W-1:0] DenB = CREDIT_W'(ValB);
    localparam logic [CREDIT_W-1:0] DenQ = CREDIT_W'(ValQ);
    localparam logic [CREDIT_W-1:0] DenD = CREDIT_W'(ValD);
    localparam logic [CREDIT_W-1:0] DenN = CREDIT_W'(ValN);
    localparam logic [CREDIT_W-1:0] DenP = CREDIT_W'(ValP);

    logic [CREDIT_W-1:0] take;

    always_comb begin
        avail_o = {remaining_i >= DenB, remaining_i >= DenQ, remaining_i >= DenD,
                   remaining_i >= DenN, remaining_i >= DenP};
        take    = '0;
        fault_o = 1'b0;
        // Several flags at once: trust the highest-value one.
        if (disp_i[4]) begin
            take = DenB;
        end else if (disp_i[3]) begin
            take = DenQ;
        end else if (disp_i[2]) begin
            take = DenD;
        end else if (disp_i[1]) begin
            take = DenN;
        end else if (disp_i[0]) begin
            take = DenP;
        end else begin
            fault_o = 1'b1;
        end
        if (take > remaining_i) begin
            fault_o = 1'b1;
        end
        remaining_o = fault_o ? '0 : remaining_i - take;
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: credit accumulation, vend decision and change-dispenser handshake.
// Optional dispenser watchdog is enabled by defining COIN_ACCEPTOR_WATCHDOG_EN.
module coin_acceptor import coin_pkg::*; #(
    parameter int unsigned PRICE    = 65,
    parameter int unsigned CREDIT_W = 9
`ifdef COIN_ACCEPTOR_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
    input logic            clk,
    input logic            reset_n,
    coin_acceptor_if.slave bus
);

    localparam int unsigned SumW = CREDIT_W + 1;

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] remaining_q;
    logic [4:0]          avail_q;
    logic                coin_reject_q;
    logic                vend_q;
    logic                insufficient_q;
    logic                change_start_q;
    logic                change_fault_q;

    logic [SumW-1:0]     coin_sum;
    logic                coin_ok;
    logic [4:0]          disp_vec;
    logic [4:0]          avail_d;
    logic [CREDIT_W-1:0] remaining_d;
    logic                sel_fault;
    logic                wd_timeout;
    logic                fault_exit;

    // Carry out of the widened sum means the credit register would overflow.
    assign coin_sum = {1'b0, credit_q} + SumW'(coin_value(bus.coin_type));
    assign coin_ok  = coin_type_valid(bus.coin_type) && !coin_sum[CREDIT_W];
    assign disp_vec = {bus.disp_B, bus.disp_Q, bus.disp_D, bus.disp_N, bus.disp_P};

    coin_change_sel #(
        .CREDIT_W (CREDIT_W)
    ) u_sel (
        .remaining_i (remaining_q),
        .disp_i      (disp_vec),
        .avail_o     (avail_d),
        .remaining_o (remaining_d),
        .fault_o     (sel_fault)
    );

`ifdef COIN_ACCEPTOR_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

    logic [WdW-1:0] wd_q;
    logic           chg_hold;

    assign chg_hold = (state_q == StChgAck && bus.change_done) ||
                      (state_q == StChgWait && !bus.change_done);
    assign wd_timeout = chg_hold && (wd_q == WdW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q <= '0;
        end else if (chg_hold && !wd_timeout) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

    assign fault_exit = wd_timeout || (state_q == StChgWait && bus.change_done && sel_fault);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StCollect;
            credit_q       <= '0;
            remaining_q    <= '0;
            avail_q        <= '0;
            coin_reject_q  <= 1'b0;
            vend_q         <= 1'b0;
            insufficient_q <= 1'b0;
            change_start_q <= 1'b0;
            change_fault_q <= 1'b0;
        end else begin
            coin_reject_q  <= bus.coin_valid &&
                              (state_q != StCollect || bus.cancel || bus.item_req || !coin_ok);
            vend_q         <= 1'b0;
            insufficient_q <= 1'b0;
            change_start_q <= 1'b0;
            if (fault_exit) begin
                change_fault_q <= 1'b1;
                remaining_q    <= '0;
                avail_q        <= '0;
                state_q        <= StCollect;
            end else begin
                unique case (state_q)
                    StCollect: begin
                        if (bus.cancel) begin
                            remaining_q <= credit_q;
                            credit_q    <= '0;
                            state_q     <= StChgReq;
                        end else if (bus.item_req) begin
                            if (credit_q >= CREDIT_W'(PRICE)) begin
                                vend_q      <= 1'b1;
                                remaining_q <= credit_q - CREDIT_W'(PRICE);
                                credit_q    <= '0;
                                state_q     <= StChgReq;
                            end else begin
                                insufficient_q <= 1'b1;
                            end
                        end else if (bus.coin_valid && coin_ok) begin
                            credit_q       <= coin_sum[CREDIT_W-1:0];
                            change_fault_q <= 1'b0;
                        end
                    end
                    StChgReq: begin
                        if (remaining_q == '0) begin
                            avail_q <= '0;
                            state_q <= StCollect;
                        end else begin
                            avail_q        <= avail_d;
                            change_start_q <= 1'b1;
                            state_q        <= StChgAck;
                        end
                    end
                    // Dispenser still shows done from its previous transaction.
                    StChgAck: begin
                        if (!bus.change_done) begin
                            state_q <= StChgWait;
                        end
                    end
                    StChgWait: begin
                        if (bus.change_done) begin
                            remaining_q <= remaining_d;
                            state_q     <= StChgReq;
                        end
                    end
                    default: state_q <= StCollect;
                endcase
            end
        end
    end

    assign bus.coin_reject  = coin_reject_q;
    assign bus.vend         = vend_q;
    assign bus.insufficient = insufficient_q;
    assign bus.busy         = (state_q != StCollect);
    assign bus.credit       = credit_q;
    assign bus.change_start = change_start_q;
    assign bus.avail_B      = avail_q[4];
    assign bus.avail_Q      = avail_q[3];
    assign bus.avail_D      = avail_q[2];
    assign bus.avail_N      = avail_q[1];
    assign bus.avail_P      = avail_q[0];
    assign bus.change_fault = change_fault_q;

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front end of the cashless-change vending path. Accumulates inserted coin credit, vends when credit covers PRICE, then drives the change dispenser's start/avail/disp/done handshake until owed change is zero. Refunds on cancel. Sits upstream of the coin-return dispenser and owns the credit register.

Parameters:
PRICE, 65, item price in cents
CREDIT_W, 9, credit/remaining register width; max credit 2^CREDIT_W-1 (511)
TIMEOUT_CYC, 1024, dispenser watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
coin_valid  in  1  one-cycle pulse, coin inserted
coin_type  in  3  0=P(1) 1=N(5) 2=D(10) 3=Q(25) 4=B(100); 5-7 invalid
item_req  in  1  purchase request pulse
cancel  in  1  refund request pulse
coin_reject  out  1  one-cycle pulse, coin not credited
vend  out  1  one-cycle pulse, item released
insufficient  out  1  one-cycle pulse, item_req with credit<PRICE
busy  out  1  high in any change state
credit  out  CREDIT_W  current credit in cents
change_start  out  1  one-cycle start pulse to dispenser
avail_B/avail_Q/avail_D/avail_N/avail_P  out  1 each  denomination fits remaining change (remaining >= value)
disp_B/disp_Q/disp_D/disp_N/disp_P  in  1 each  dispenser coin-issued flags
change_done  in  1  dispenser done level
change_fault  out  1  sticky; cleared by reset or next accepted coin

Behaviour:
- Reset (async, reset_n=0): state COLLECT; credit=0, remaining=0; all outputs 0.
- States: COLLECT, CHG_REQ, CHG_ACK, CHG_WAIT.
- COLLECT priority per cycle: cancel > item_req > coin_valid. A coin arriving with cancel or item_req in the same cycle -> coin_reject, no credit.
- Coin: valid type and credit+value <= 2^CREDIT_W-1 -> credit += value next cycle. Otherwise coin_reject pulse and credit unchanged.
- item_req with credit>=PRICE -> vend pulse; remaining=credit-PRICE; credit=0; -> CHG_REQ.
- item_req with credit<PRICE -> insufficient pulse; stay in COLLECT.
- cancel -> remaining=credit; credit=0; -> CHG_REQ. Cancel with credit 0 -> CHG_REQ, which exits immediately.
- CHG_REQ: remaining==0 -> COLLECT, no start. Else drive avail_* from remaining, pulse change_start for 1 cycle, -> CHG_ACK.
- avail_* are registered. They are held stable from CHG_REQ until CHG_WAIT exits.
- CHG_ACK: wait for change_done==0, since the dispenser holds done high from its previous transaction. -> CHG_WAIT.
- CHG_WAIT: on change_done==1, sample disp_*. Take the highest-value set bit and subtract its value from remaining. -> CHG_REQ.
- If no disp bit is set, or the sampled value exceeds remaining: set change_fault, zero remaining, -> COLLECT.
- Coins received in any CHG_* state -> coin_reject. item_req and cancel are ignored there.
- busy=1 in CHG_REQ/CHG_ACK/CHG_WAIT.
- Latency: coin to updated credit is 1 cycle; item_req to vend is 1 cycle; minimum 3 cycles per dispensed coin.

Optional Feature:
COIN_ACCEPTOR_WATCHDOG_EN
- Defined: a counter runs in CHG_ACK/CHG_WAIT and clears on state exit. Reaching TIMEOUT_CYC sets change_fault, zeroes remaining, -> COLLECT.
- Undefined: no counter. CHG_ACK/CHG_WAIT wait indefinitely, and TIMEOUT_CYC is unused.

Decomposition:
- Package coin_pkg holds: the coin_type encodings, the cent value constants (1/5/10/25/100), the state encoding, and a function mapping coin_type to value.
- One natural sub-module, coin_change_sel (combinational). Inputs: remaining and disp_*. Outputs: avail_* and the decremented value plus a fault flag.
- The FSM and counters stay in coin_acceptor.

Test Plan:
- Insert Q,Q,D (60), item_req -> insufficient=1, credit stays 60. Insert N (65), item_req -> vend=1, credit=0, no change_start.
- Credit 100 (B), item_req -> vend, remaining=35, avail Q/D/N/P=1, avail_B=0. Model dispenser: disp_Q then disp_D -> two change_start pulses, return to COLLECT, busy falls.
- Credit 41 (Q,D,N,P), cancel -> four dispense rounds Q,D,N,P; final remaining 0; no vend.
- Credit 500, insert B -> coin_reject, credit 500. Insert coin_type=6 -> coin_reject.
- Coin same cycle as item_req -> coin_reject and item_req processed. Coin during CHG_WAIT -> coin_reject. Reset asserted mid-CHG_WAIT -> all outputs 0 and credit 0 immediately.
- Dispenser returns done with no disp bit -> change_fault=1, COLLECT. With the watchdog enabled, change_done stuck at 0 for 1024 cycles -> change_fault=1.
